// File: rtl/alu_defs.sv
// Shared opcode constants and FSM encodings for the sequential execute unit.
// The R-type controller imports the same constants so both add codes stay in sync.
package alu_defs;

   localparam int unsigned OP_W = 4;

   localparam logic [OP_W-1:0] ALUOP_SLL     = 4'h0;
   localparam logic [OP_W-1:0] ALUOP_SRL     = 4'h2;
   localparam logic [OP_W-1:0] ALUOP_SRA     = 4'h3;
   localparam logic [OP_W-1:0] ALUOP_SLT     = 4'h5;
   localparam logic [OP_W-1:0] ALUOP_ADD     = 4'h8;
   localparam logic [OP_W-1:0] ALUOP_SUB     = 4'hA;
   localparam logic [OP_W-1:0] ALUOP_ADD_ALT = 4'hB;
   localparam logic [OP_W-1:0] ALUOP_AND     = 4'hC;
   localparam logic [OP_W-1:0] ALUOP_OR      = 4'hD;
   localparam logic [OP_W-1:0] ALUOP_NOR     = 4'hF;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_SHIFT = 2'd1,
      ST_DONE  = 2'd2
   } state_t;

   function automatic logic is_shift(input logic [OP_W-1:0] op);
      return (op == ALUOP_SLL) || (op == ALUOP_SRL) || (op == ALUOP_SRA);
   endfunction

   function automatic logic is_legal(input logic [OP_W-1:0] op);
      return is_shift(op) || (op == ALUOP_SLT) || (op == ALUOP_ADD) ||
             (op == ALUOP_ADD_ALT) || (op == ALUOP_SUB) || (op == ALUOP_AND) ||
             (op == ALUOP_OR) || (op == ALUOP_NOR);
   endfunction

endpackage

// File: rtl/alu_comb.sv
// Single-cycle function unit for every non-shift op; unsupported codes yield zero.
module alu_comb
   import alu_defs::*;
#(
   parameter int unsigned WIDTH = 32
) (
   input  logic [OP_W-1:0]  aluop,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic [WIDTH-1:0] result_c,
   output logic             ovf_c
);

   logic [WIDTH-1:0] b_neg;
   logic [WIDTH-1:0] sum;
   logic [WIDTH-1:0] diff;

   assign b_neg = ~b + WIDTH'(1);
   assign sum   = a + b;
   assign diff  = a + b_neg;

   // Overflow: operands agree in sign but the wrapped result does not.
   always_comb begin
      result_c = '0;
      ovf_c    = 1'b0;
      case (aluop)
         ALUOP_ADD, ALUOP_ADD_ALT: begin
            result_c = sum;
            ovf_c    = (a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
         end
         ALUOP_SUB: begin
            result_c = diff;
            ovf_c    = (a[WIDTH-1] == b_neg[WIDTH-1]) && (diff[WIDTH-1] != a[WIDTH-1]);
         end
         ALUOP_SLT: result_c = WIDTH'($signed(a) < $signed(b));
         ALUOP_AND: result_c = a & b;
         ALUOP_OR:  result_c = a | b;
         ALUOP_NOR: result_c = ~(a | b);
         default:   result_c = '0;
      endcase
   end

endmodule

// File: rtl/alu_seq.sv
// Multi-cycle execute unit: one-cycle logic/arith ops, serial one-bit-per-cycle shifts,
// valid/ready handshake on both sides.
module alu_seq
   import alu_defs::*;
#(
   parameter int unsigned WIDTH = 32,
   parameter int unsigned SHW   = 5
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [OP_W-1:0]  aluop,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic [SHW-1:0]   shamt,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] result,
   output logic             zero,
   output logic             ovf,
   output logic             bad_op
);

   state_t           state_q, state_d;
   logic [OP_W-1:0]  op_q, op_d;
   logic [WIDTH-1:0] acc_q, acc_d;
   logic [SHW-1:0]   cnt_q, cnt_d;
   logic [WIDTH-1:0] result_d;
   logic             zero_d, ovf_d, bad_op_d;

   logic [WIDTH-1:0] comb_res;
   logic             comb_ovf;

   alu_comb #(.WIDTH(WIDTH)) u_comb (
      .aluop    (aluop),
      .a        (a),
      .b        (b),
      .result_c (comb_res),
      .ovf_c    (comb_ovf)
   );

   always_comb begin
      state_d  = state_q;
      op_d     = op_q;
      acc_d    = acc_q;
      cnt_d    = cnt_q;
      result_d = result;
      zero_d   = zero;
      ovf_d    = ovf;
      bad_op_d = bad_op;
      case (state_q)
         ST_IDLE: begin
            if (in_valid && in_ready) begin
               op_d = aluop;
               if (is_shift(aluop)) begin
                  acc_d   = b;
                  cnt_d   = shamt;
                  state_d = ST_SHIFT;
               end else begin
                  result_d = comb_res;
                  zero_d   = (comb_res == '0);
                  ovf_d    = comb_ovf;
                  bad_op_d = !is_legal(aluop);
                  state_d  = ST_DONE;
               end
            end
         end
         // One bit position per cycle; the count reaching zero publishes the accumulator.
         ST_SHIFT: begin
            if (cnt_q == '0) begin
               result_d = acc_q;
               zero_d   = (acc_q == '0);
               ovf_d    = 1'b0;
               bad_op_d = 1'b0;
               state_d  = ST_DONE;
            end else begin
               case (op_q)
                  ALUOP_SLL: acc_d = {acc_q[WIDTH-2:0], 1'b0};
                  ALUOP_SRL: acc_d = {1'b0, acc_q[WIDTH-1:1]};
                  default:   acc_d = {acc_q[WIDTH-1], acc_q[WIDTH-1:1]};
               endcase
               cnt_d = cnt_q - SHW'(1);
            end
         end
         ST_DONE: begin
            if (out_ready) state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= ST_IDLE;
         op_q      <= '0;
         acc_q     <= '0;
         cnt_q     <= '0;
         result    <= '0;
         zero      <= 1'b1;
         ovf       <= 1'b0;
         bad_op    <= 1'b0;
         in_ready  <= 1'b1;
         out_valid <= 1'b0;
      end else begin
         state_q   <= state_d;
         op_q      <= op_d;
         acc_q     <= acc_d;
         cnt_q     <= cnt_d;
         result    <= result_d;
         zero      <= zero_d;
         ovf       <= ovf_d;
         bad_op    <= bad_op_d;
         in_ready  <= (state_d == ST_IDLE);
         out_valid <= (state_d == ST_DONE);
      end
   end

endmodule

// File: tb/tb_alu_seq.sv
// Scoreboard bench for alu_seq: a reference model pushes expectations at issue,
// they are popped and compared when out_valid rises.
module tb_alu_seq;
   import alu_defs::*;

   localparam int unsigned WIDTH = 32;
   localparam int unsigned SHW   = 5;

   typedef struct {
      logic [WIDTH-1:0] res;
      logic             zero;
      logic             ovf;
      logic             bad;
      int               lat;
   } exp_t;

   logic             clk = 1'b0;
   logic             rst = 1'b1;
   logic             in_valid = 1'b0;
   logic             in_ready;
   logic [OP_W-1:0]  aluop = '0;
   logic [WIDTH-1:0] a = '0;
   logic [WIDTH-1:0] b = '0;
   logic [SHW-1:0]   shamt = '0;
   logic             out_valid;
   logic             out_ready = 1'b1;
   logic [WIDTH-1:0] result;
   logic             zero, ovf, bad_op;

   int   checks = 0;
   int   errors = 0;
   exp_t sb[$];

   alu_seq #(.WIDTH(WIDTH), .SHW(SHW)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
      .aluop(aluop), .a(a), .b(b), .shamt(shamt),
      .out_valid(out_valid), .out_ready(out_ready), .result(result),
      .zero(zero), .ovf(ovf), .bad_op(bad_op)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [WIDTH-1:0] got, input logic [WIDTH-1:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %h exp %h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   function automatic exp_t model(input logic [3:0] op, input logic [WIDTH-1:0] x,
                                  input logic [WIDTH-1:0] y, input logic [SHW-1:0] sh);
      exp_t e;
      logic [WIDTH-1:0] yn;
      e.ovf = 1'b0;
      e.bad = 1'b0;
      e.lat = 1;
      yn    = ~y + 32'd1;
      case (op)
         4'h0: begin e.res = x * 0 + (y << sh);                    e.lat = int'(sh) + 2; end
         4'h2: begin e.res = y >> sh;                              e.lat = int'(sh) + 2; end
         4'h3: begin e.res = WIDTH'($signed(y) >>> sh);            e.lat = int'(sh) + 2; end
         4'h5: e.res = ($signed(x) < $signed(y)) ? 32'd1 : 32'd0;
         4'h8, 4'hB: begin
            e.res = x + y;
            e.ovf = (x[31] == y[31]) && (e.res[31] != x[31]);
         end
         4'hA: begin
            e.res = x - y;
            e.ovf = (x[31] == yn[31]) && (e.res[31] != x[31]);
         end
         4'hC: e.res = x & y;
         4'hD: e.res = x | y;
         4'hF: e.res = ~(x | y);
         default: begin e.res = '0; e.bad = 1'b1; end
      endcase
      e.zero = (e.res == '0);
      return e;
   endfunction

   // Issue one request from a negedge and wait (bounded) for its result.
   task automatic run(input logic [3:0] op, input logic [WIDTH-1:0] x,
                      input logic [WIDTH-1:0] y, input logic [SHW-1:0] sh);
      exp_t e;
      int   lat;
      sb.push_back(model(op, x, y, sh));
      chk("in_ready_idle", WIDTH'(in_ready), 32'd1);
      aluop = op; a = x; b = y; shamt = sh; in_valid = 1'b1;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      a = $urandom; b = $urandom; shamt = SHW'($urandom); aluop = 4'($urandom);
      @(negedge clk);
      lat = 1;
      while (!out_valid && lat < 100) begin
         @(negedge clk);
         lat++;
      end
      e = sb.pop_front();
      if (!out_valid) chk("out_valid_timeout", 32'd0, 32'd1);
      chk("latency", WIDTH'(lat), WIDTH'(e.lat));
      chk("result", result, e.res);
      chk("zero", WIDTH'(zero), WIDTH'(e.zero));
      chk("ovf", WIDTH'(ovf), WIDTH'(e.ovf));
      chk("bad_op", WIDTH'(bad_op), WIDTH'(e.bad));
      chk("in_ready_busy", WIDTH'(in_ready), 32'd0);
   endtask

   task automatic drain();
      out_ready = 1'b1;
      @(negedge clk);
      chk("drain_out_valid", WIDTH'(out_valid), 32'd0);
      chk("drain_in_ready", WIDTH'(in_ready), 32'd1);
   endtask

   initial begin
      logic [3:0] ops [13];
      ops = '{4'h0, 4'h2, 4'h3, 4'h5, 4'h8, 4'hB, 4'hA, 4'hC, 4'hD, 4'hF, 4'h1, 4'h4, 4'hE};

      repeat (2) @(negedge clk);
      chk("rst_in_ready", WIDTH'(in_ready), 32'd1);
      chk("rst_out_valid", WIDTH'(out_valid), 32'd0);
      chk("rst_result", result, 32'd0);
      chk("rst_zero", WIDTH'(zero), 32'd1);
      chk("rst_ovf", WIDTH'(ovf), 32'd0);
      chk("rst_bad_op", WIDTH'(bad_op), 32'd0);
      rst = 1'b0;
      @(negedge clk);

      // Directed cases.
      run(4'h8, 32'h7FFF_FFFF, 32'h1, 5'd0);        drain();
      run(4'hB, 32'h7FFF_FFFF, 32'h1, 5'd0);        drain();
      run(4'hA, 32'h1234_5678, 32'h1234_5678, 5'd0); drain();
      run(4'h5, 32'hFFFF_FFFF, 32'h1, 5'd0);        drain();
      run(4'h3, 32'h0, 32'h8000_0000, 5'd4);        drain();
      run(4'h2, 32'h0, 32'h8000_0000, 5'd4);        drain();
      run(4'h0, 32'h0, 32'h1, 5'd31);               drain();
      run(4'h0, 32'h0, 32'hA5A5_0F0F, 5'd0);        drain();
      run(4'h1, 32'hDEAD_BEEF, 32'h1, 5'd0);        drain();
      run(4'hA, 32'h8000_0000, 32'h1, 5'd0);        drain();

      // Backpressure: result held, new requests ignored while stalled.
      out_ready = 1'b0;
      run(4'hD, 32'hF0, 32'h0F, 5'd0);
      for (int i = 0; i < 5; i++) begin
         in_valid = (i % 2 == 0);
         aluop = 4'h8; a = 32'h1; b = 32'h1;
         @(negedge clk);
         chk("stall_out_valid", WIDTH'(out_valid), 32'd1);
         chk("stall_result", result, 32'hFF);
         chk("stall_in_ready", WIDTH'(in_ready), 32'd0);
      end
      in_valid = 1'b0;
      drain();
      chk("stall_result_after", result, 32'hFF);

      // Reset in the middle of a long shift.
      aluop = 4'h0; b = 32'h1; shamt = 5'd20; in_valid = 1'b1;
      @(posedge clk);
      #1 in_valid = 1'b0;
      repeat (4) @(negedge clk);
      chk("midshift_busy", WIDTH'(in_ready), 32'd0);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      chk("midrst_out_valid", WIDTH'(out_valid), 32'd0);
      chk("midrst_in_ready", WIDTH'(in_ready), 32'd1);
      chk("midrst_result", result, 32'd0);
      run(4'hF, 32'h0, 32'h0, 5'd0);                drain();

      // Reset and request together: reset wins.
      rst = 1'b1; in_valid = 1'b1; aluop = 4'hD; a = 32'h5; b = 32'h0;
      @(negedge clk);
      rst = 1'b0; in_valid = 1'b0;
      @(negedge clk);
      chk("rst_wins_out_valid", WIDTH'(out_valid), 32'd0);
      chk("rst_wins_in_ready", WIDTH'(in_ready), 32'd1);

      // Random mix over legal and illegal codes.
      for (int i = 0; i < 40; i++) begin
         run(ops[$urandom_range(0, 12)], $urandom, $urandom, SHW'($urandom_range(0, 31)));
         drain();
      end

      chk("scoreboard_empty", WIDTH'(sb.size()), 32'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL global_timeout got %0t exp <500000", $time);
      $fatal(1, "timeout");
   end

endmodule
